leaf_out_arbiter: RTL
=====================

# leaf_out_arbiter

Shares a leaf's single outbound BFT packet port among `NUM_OUT_PORTS` user output streams. It sits between the user kernel's AXI-stream-style outputs and the leaf's BFT egress. Each cycle it picks one eligible stream by round-robin, stamps a routing header and per-port sequence address on the 32-bit payload, and registers the result as one 49-bit packet. Each stream is flow-controlled by a credit counter that tracks free space at its destination and is replenished by freespace-update events.

## Interface
- `NUM_OUT_PORTS`, 2: user output streams arbitrated (1..16).
- `PAYLOAD_BITS`, 32: payload width.
- `NUM_LEAF_BITS`, 5: destination leaf field width.
- `NUM_PORT_BITS`, 4: destination port field width.
- `NUM_ADDR_BITS`, 7: sequence address field width.
- `PACKET_BITS`, 49: must equal 1+`NUM_LEAF_BITS`+`NUM_PORT_BITS`+`NUM_ADDR_BITS`+`PAYLOAD_BITS`.
- `FREESPACE_UPDATE_SIZE`, 64: initial credits per port; also the credit cap.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_user_data` in `NUM_OUT_PORTS*PAYLOAD_BITS`: stream i occupies slice [i*32 +: 32].
- `i_user_valid` in `NUM_OUT_PORTS`: per-stream valid.
- `o_user_ready` in/out: output, `NUM_OUT_PORTS` wide; one-hot grant (combinational).
- `o_bft_data` out `PACKET_BITS`: registered packet; bit 48 is the valid bit.
- `i_bft_ready` in 1: egress can accept; this is the leaf's `resend` signal.
- `i_credit_valid` in 1: freespace update strobe.
- `i_credit_port` in `NUM_PORT_BITS`: local stream index being replenished.
- `i_credit_amount` in 8: credits returned (0..255).
- `cfg_we` in 1: write the destination config for one stream.
- `cfg_port` in `NUM_PORT_BITS`: stream index to configure.
- `cfg_dest_leaf` in `NUM_LEAF_BITS`: destination leaf for that stream.
- `cfg_dest_port` in `NUM_PORT_BITS`: destination port for that stream.

## Operation
- **Packet layout.** [48] valid=1, [47:43] dest leaf, [42:39] dest port, [38:32] seq addr, [31:0] payload.
- **Slot.** The output register is free when `o_bft_data[48]==0` or `i_bft_ready==1`.
- **Eligibility.** Stream i is eligible when `i_user_valid[i]` is high and `credit[i] != 0`.
- **Grant.** When the slot is free and at least one stream is eligible, exactly one `o_user_ready[i]` goes high.
  - The winner is the first eligible index after `last_grant`, searching round-robin with wrap.
  - Otherwise `o_user_ready` is 0.
  - The ready signal never depends on the stream's own valid beyond the eligibility test.
- **Transfer.** A transfer happens when `o_user_ready[i] & i_user_valid[i]`. On that edge:
  - the packet is loaded;
  - `last_grant <= i`;
  - `seq[i]` increments, wrapping from 127 to 0;
  - `credit[i]` decrements.
- **Slot free, no transfer.** `o_bft_data[48]` clears to 0; the data field is don't-care and holds its last value.
- **Slot busy.** When `o_bft_data[48]==1` and `i_bft_ready==0`, the register holds stable.
- **Credit update.** `credit[p] <= min(credit[p] + amount, FREESPACE_UPDATE_SIZE)`.
  - If a transfer on p happens in the same cycle, the net is `+amount-1`, then saturated.
  - Updates to p ≥ `NUM_OUT_PORTS` are ignored.
  - The credit width is clog2(`FREESPACE_UPDATE_SIZE`+1).
- **Config.** A `cfg_we` write takes effect on the next packet.
  - A write in the same cycle as a transfer on that port uses the old value.
  - Writes to an out-of-range `cfg_port` are ignored.
- **Reset values.**
  - `o_bft_data` = 0.
  - `last_grant` = `NUM_OUT_PORTS`-1, so port 0 wins first.
  - All `seq` = 0.
  - All `credit` = `FREESPACE_UPDATE_SIZE`.
  - All dest config = 0.
  - `o_user_ready` = 0 while reset is high.
- **Reset mid-operation.** Any held packet is dropped and no grant is issued that cycle.

## Timing
- Latency is 1 cycle from user transfer to `o_bft_data` valid.
- Sustained throughput is 1 packet/cycle while `i_bft_ready` is high.
- Grant path: combinational from `i_user_valid`, `credit`, `i_bft_ready` and `o_bft_data[48]` to `o_user_ready`. No combinational path exists from `i_credit_*` or `cfg_*` to outputs.
- The arbiter is fair: with N streams continuously eligible, each receives exactly one grant per N consecutive transfers.
- A stream reaching credit 0 is skipped starting the cycle after its last transfer. It becomes eligible the cycle after a nonzero credit update.

## Test plan
- **Reset and single stream.** After reset, configure port0 → leaf 3, port 2, then drive stream0 payloads 0xA0..0xA2.
  - Required: `o_bft_data` = {1,5'd3,4'd2,7'd0,0xA0}, then seq 1, 2, on consecutive cycles.
- **Round-robin.** Keep both streams valid continuously.
  - Required: grants alternate 0,1,0,1.
  - Required: seq for each port increments independently.
- **Backpressure.** Hold `i_bft_ready`=0 for 5 cycles with a packet held.
  - Required: `o_bft_data` is stable and `o_user_ready`=0.
  - Required: the first cycle after release issues a new grant.
- **Credit exhaustion.** Send 64 packets on stream0 with no updates.
  - Required: the 65th is not granted while stream1 still flows.
  - Required: after credit update (port 0, amount 10), stream0 resumes and can send exactly 10 more.
- **Boundaries.**
  - Update (port 0, amount 255) at full credit: stays 64.
  - Update coincident with a transfer at credit 1: yields credit = amount.
  - 128 transfers on one port: seq wraps 127 → 0.
- **Mid-stream reset.** Assert reset while a packet is held.
  - Required: the next cycle has `o_bft_data`=0, credits 64, and port 0 wins first.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin share of one BFT egress among user streams, each gated by its own destination credit count.
// One cycle from user transfer to registered packet; a held, unaccepted packet blocks all grants until i_bft_ready.
module leaf_out_arbiter #(
    parameter int NUM_OUT_PORTS         = 2,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PACKET_BITS           = 49,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   i_user_data,
    input  logic [NUM_OUT_PORTS-1:0]                i_user_valid,
    output logic [NUM_OUT_PORTS-1:0]                o_user_ready,
    output logic [PACKET_BITS-1:0]                  o_bft_data,
    input  logic                                    i_bft_ready,
    input  logic                                    i_credit_valid,
    input  logic [NUM_PORT_BITS-1:0]                i_credit_port,
    input  logic [7:0]                              i_credit_amount,
    input  logic                                    cfg_we,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port
);
    localparam int CW  = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int LGW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
    logic [LGW-1:0]           last_grant_q, last_grant_d;
    logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q    [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d    [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];

    logic                     slot_free;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [NUM_OUT_PORTS-1:0] xfer;
    logic                     gnt_any;
    int                       cand;
    int                       csum;

    assign slot_free    = !pkt_q[PACKET_BITS-1] || i_bft_ready;
    assign o_user_ready = grant;
    assign xfer         = grant & i_user_valid;
    assign o_bft_data   = pkt_q;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = i_user_valid[i] && (credit_q[i] != '0);
        end
    end

    // Search starts one past the last winner so every eligible stream is reached within N grants.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_OUT_PORTS;
            if (!gnt_any && !reset && slot_free && eligible[cand]) begin
                gnt_any     = 1'b1;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        pkt_d        = pkt_q;
        last_grant_d = last_grant_q;
        if (slot_free) begin
            pkt_d[PACKET_BITS-1] = 1'b0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (xfer[i]) begin
                    pkt_d = {1'b1, dest_leaf_q[i], dest_port_q[i], seq_q[i],
                             i_user_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
                    last_grant_d = LGW'(i);
                end
            end
        end
    end

    // A transfer only happens at nonzero credit, so the decrement never underflows before saturation.
    always_comb begin
        csum = 0;
        for (int p = 0; p < NUM_OUT_PORTS; p++) begin
            csum = int'(credit_q[p]);
            if (i_credit_valid && (int'(i_credit_port) == p)) begin
                csum = csum + int'(i_credit_amount);
            end
            if (xfer[p]) begin
                csum = csum - 1;
            end
            if (csum > FREESPACE_UPDATE_SIZE) begin
                csum = FREESPACE_UPDATE_SIZE;
            end
            credit_d[p] = CW'(csum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q        <= '0;
            last_grant_q <= LGW'(NUM_OUT_PORTS - 1);
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                seq_q[i]       <= '0;
                credit_q[i]    <= CW'(FREESPACE_UPDATE_SIZE);
                dest_leaf_q[i] <= '0;
                dest_port_q[i] <= '0;
            end
        end else begin
            pkt_q        <= pkt_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
                if (xfer[i]) begin
                    seq_q[i] <= seq_q[i] + 1'b1;
                end
                if (cfg_we && (int'(cfg_port) == i)) begin
                    dest_leaf_q[i] <= cfg_dest_leaf;
                    dest_port_q[i] <= cfg_dest_port;
                end
            end
        end
    end

endmodule
